// File: rtl/gray_sample_fifo.sv
// Gray-coded sample qualifier: converts non-zero gray_count words to binary,
// computes the wrap-around delta to the previous sample and queues them in a show-ahead FIFO.
module gray_sample_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [WIDTH-1:0]         gray_in,
    input  logic                     clr_ovf,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_bin,
    output logic [WIDTH-1:0]         out_delta,
    output logic                     out_first,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] s1_gray;
    logic             s1_valid;

    logic [WIDTH-1:0] s2_bin;
    logic [WIDTH-1:0] s2_delta;
    logic             s2_first;

    logic [WIDTH-1:0] last_bin;
    logic             have_prev;

    logic [WIDTH-1:0] mem_bin   [DEPTH];
    logic [WIDTH-1:0] mem_delta [DEPTH];
    logic             mem_first [DEPTH];

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;

    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    // A zero word from the pulse counter means "no window completed", never a sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_gray  <= '0;
        end else begin
            s1_valid <= enable && (gray_in != '0);
            if (enable && (gray_in != '0))
                s1_gray <= gray_in;
        end
    end

    always_comb begin
        s2_bin = '0;
        for (int i = 0; i < WIDTH; i++)
            s2_bin[i] = ^(s1_gray >> i);
        s2_delta = have_prev ? (s2_bin - last_bin) : '0;
        s2_first = ~have_prev;
    end

    assign full      = (count == LW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push_ok   = s1_valid && (!full || pop);
    assign drop      = s1_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_bin[wr_ptr]   <= s2_bin;
            mem_delta[wr_ptr] <= s2_delta;
            mem_first[wr_ptr] <= s2_first;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // The delta reference follows every sample, including ones dropped on a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_bin  <= '0;
            have_prev <= 1'b0;
        end else if (s1_valid) begin
            last_bin  <= s2_bin;
            have_prev <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

    assign out_bin   = out_valid ? mem_bin[rd_ptr]   : '0;
    assign out_delta = out_valid ? mem_delta[rd_ptr] : '0;
    assign out_first = out_valid ? mem_first[rd_ptr] : 1'b0;
    assign level     = count;

endmodule

// File: tb/tb_gray_sample_fifo.sv
// Self-checking bench for gray_sample_fifo: directed vector table, hand-written
// reset/idle sequences and randomized traffic against a queue-based reference model.
module tb_gray_sample_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] gray_in;
    logic             clr_ovf;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_bin;
    logic [WIDTH-1:0] out_delta;
    logic             out_first;
    logic [2:0]       level;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    gray_sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .gray_in(gray_in),
        .clr_ovf(clr_ovf),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_bin(out_bin),
        .out_delta(out_delta),
        .out_first(out_first),
        .level(level),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] bin;
        logic [7:0] delta;
        logic       first;
    } entry_t;

    typedef struct {
        logic       en;
        logic [7:0] gray;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] eb;
        logic [7:0] ed;
        logic       ef;
        logic [2:0] el;
        logic       eo;
    } vec_t;

    // Reference model: the FIFO is a plain queue, the stage-1 register a pending sample.
    entry_t     mq[$];
    logic       m_pend;
    logic [7:0] m_pend_gray;
    logic [7:0] m_last;
    logic       m_have;
    logic       m_ovf;
    vec_t       vecs[$];

    function automatic logic [7:0] grayToBin(input logic [7:0] g);
        for (int b = 0; b < 256; b++)
            if (8'(b ^ (b >> 1)) == g)
                return 8'(b);
        return 8'h00;
    endfunction

    task automatic modelReset();
        mq.delete();
        m_pend      = 1'b0;
        m_pend_gray = 8'h00;
        m_last      = 8'h00;
        m_have      = 1'b0;
        m_ovf       = 1'b0;
    endtask

    task automatic modelStep(input logic en, input logic [7:0] g, input logic rdy, input logic clr);
        logic   popped;
        logic   dropped;
        entry_t e;
        popped  = (mq.size() != 0) && rdy;
        dropped = 1'b0;
        if (popped)
            void'(mq.pop_front());
        if (m_pend) begin
            e.bin   = grayToBin(m_pend_gray);
            e.delta = m_have ? 8'(e.bin - m_last) : 8'h00;
            e.first = !m_have;
            if (mq.size() < DEPTH)
                mq.push_back(e);
            else
                dropped = 1'b1;
            m_last = e.bin;
            m_have = 1'b1;
        end
        if (dropped)
            m_ovf = 1'b1;
        else if (clr)
            m_ovf = 1'b0;
        m_pend      = en && (g != 8'h00);
        m_pend_gray = g;
    endtask

    task automatic cmp(input string name, input string field, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s %s: got %0h expected %0h", name, field, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [7:0] eb,
                               input logic [7:0] ed, input logic ef, input logic [2:0] el,
                               input logic eo);
        cmp(name, "out_valid", 8'(out_valid), 8'(ev));
        cmp(name, "out_bin",   out_bin,       eb);
        cmp(name, "out_delta", out_delta,     ed);
        cmp(name, "out_first", 8'(out_first), 8'(ef));
        cmp(name, "level",     8'(level),     8'(el));
        cmp(name, "overflow",  8'(overflow),  8'(eo));
    endtask

    task automatic checkModel(input string name);
        if (mq.size() != 0)
            checkOutput(name, 1'b1, mq[0].bin, mq[0].delta, mq[0].first, 3'(mq.size()), m_ovf);
        else
            checkOutput(name, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, m_ovf);
    endtask

    task automatic applyStimulus(input logic en, input logic [7:0] g, input logic rdy, input logic clr);
        enable    = en;
        gray_in   = g;
        out_ready = rdy;
        clr_ovf   = clr;
        modelStep(en, g, rdy, clr);
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        reset = 1'b1;
        enable = 1'b0; gray_in = 8'h00; out_ready = 1'b0; clr_ovf = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic en, input logic [7:0] g, input logic rdy, input logic clr,
                          input logic ev, input logic [7:0] eb, input logic [7:0] ed,
                          input logic ef, input logic [2:0] el, input logic eo);
        vec_t v;
        v.en = en; v.gray = g; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.eb = eb; v.ed = ed; v.ef = ef; v.el = el; v.eo = eo;
        vecs.push_back(v);
    endtask

    initial begin
        // en gray rdy clr | valid bin delta first level ovf
        addVec(1, 8'h06, 1, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        addVec(1, 8'h0C, 1, 0,  1, 8'h04, 8'h00, 1, 1, 0);
        addVec(1, 8'h00, 1, 0,  1, 8'h08, 8'h04, 0, 1, 0);
        addVec(1, 8'h80, 1, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        addVec(1, 8'h01, 1, 0,  1, 8'hFF, 8'hF7, 0, 1, 0);
        addVec(1, 8'h00, 1, 0,  1, 8'h01, 8'h02, 0, 1, 0);
        addVec(1, 8'h00, 0, 0,  1, 8'h01, 8'h02, 0, 1, 0);
        addVec(1, 8'h00, 1, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        addVec(1, 8'h01, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        addVec(1, 8'h03, 0, 0,  1, 8'h01, 8'h00, 0, 1, 0);
        addVec(1, 8'h02, 0, 0,  1, 8'h01, 8'h00, 0, 2, 0);
        addVec(1, 8'h06, 0, 0,  1, 8'h01, 8'h00, 0, 3, 0);
        addVec(1, 8'h07, 0, 0,  1, 8'h01, 8'h00, 0, 4, 0);
        addVec(1, 8'h00, 0, 0,  1, 8'h01, 8'h00, 0, 4, 1);
        addVec(1, 8'h00, 1, 0,  1, 8'h02, 8'h01, 0, 3, 1);
        addVec(1, 8'h00, 1, 0,  1, 8'h03, 8'h01, 0, 2, 1);
        addVec(1, 8'h00, 1, 0,  1, 8'h04, 8'h01, 0, 1, 1);
        addVec(1, 8'h0F, 1, 0,  0, 8'h00, 8'h00, 0, 0, 1);
        addVec(1, 8'h00, 0, 0,  1, 8'h0A, 8'h05, 0, 1, 1);
        addVec(1, 8'h00, 1, 0,  0, 8'h00, 8'h00, 0, 0, 1);
        addVec(0, 8'h06, 1, 0,  0, 8'h00, 8'h00, 0, 0, 1);
        addVec(0, 8'h06, 1, 0,  0, 8'h00, 8'h00, 0, 0, 1);
        addVec(1, 8'h00, 1, 0,  0, 8'h00, 8'h00, 0, 0, 1);
        addVec(1, 8'h00, 0, 1,  0, 8'h00, 8'h00, 0, 0, 0);
        addVec(1, 8'h03, 0, 0,  0, 8'h00, 8'h00, 0, 0, 0);
        addVec(1, 8'h03, 0, 0,  1, 8'h02, 8'hF8, 0, 1, 0);
        addVec(1, 8'h03, 0, 0,  1, 8'h02, 8'hF8, 0, 2, 0);
        addVec(1, 8'h03, 0, 0,  1, 8'h02, 8'hF8, 0, 3, 0);
        addVec(1, 8'h06, 0, 0,  1, 8'h02, 8'hF8, 0, 4, 0);
        addVec(1, 8'h00, 1, 0,  1, 8'h02, 8'h00, 0, 4, 0);
        addVec(1, 8'h07, 0, 0,  1, 8'h02, 8'h00, 0, 4, 0);
        addVec(1, 8'h00, 0, 1,  1, 8'h02, 8'h00, 0, 4, 1);
        addVec(1, 8'h00, 0, 1,  1, 8'h02, 8'h00, 0, 4, 0);

        doReset();
        checkOutput("reset_state", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].en, vecs[i].gray, vecs[i].rdy, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].eb, vecs[i].ed,
                        vecs[i].ef, vecs[i].el, vecs[i].eo);
        end

        // Asynchronous reset with two entries queued, then first-sample semantics afterwards.
        doReset();
        applyStimulus(1, 8'h06, 0, 0);
        applyStimulus(1, 8'h0C, 0, 0);
        applyStimulus(1, 8'h00, 0, 0);
        checkOutput("pre_reset", 1'b1, 8'h04, 8'h00, 1'b1, 3'd2, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        modelReset();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(1, 8'h0C, 1, 0);
        applyStimulus(1, 8'h00, 1, 0);
        checkOutput("first_after_reset", 1'b1, 8'h08, 8'h00, 1'b1, 3'd1, 1'b0);
        applyStimulus(1, 8'h00, 1, 0);

        // Zero words and disabled captures never produce samples.
        for (int c = 0; c < 10; c++) begin
            applyStimulus(1, 8'h00, 1, 0);
            checkOutput("idle_zero", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 8'h06, 1, 0);
            checkOutput("idle_disabled", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0);
        end

        // Randomized traffic with phases of slow and fast draining.
        doReset();
        for (int c = 0; c < 1200; c++) begin
            logic       en;
            logic [7:0] g;
            logic       rdy;
            logic       clr;
            en  = ($urandom_range(0, 9) != 0);
            g   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            rdy = ((c / 100) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            applyStimulus(en, g, rdy, clr);
            checkModel("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
